psum_accum_writer: RTL
======================

// Module: psum_accum_writer
// PURPOSE
//  Downstream of the MAC-array controller: drains the output FIFO into psum memory (pmem).
//  Set 0 of a job writes rows straight to pmem; each later set read-modify-writes (pmem += ofifo row).
//  After the last row of the last set is committed, pulses done; pmem then holds the final psums.
// PARAMETERS
//  COL      8   columns per ofifo row
//  PSUM_BW  16  signed psum width per column
//  ADDR_W   4   pmem address width (depth 2**ADDR_W)
// PORTS
//  clk          in   1            clock, rising edge
//  reset        in   1            asynchronous, active-high reset
//  start        in   1            1-cycle pulse: latch num_rows/num_sets, begin job (ignored when busy)
//  num_rows     in   5            rows per set, 1..16 (0 treated as 1)
//  num_sets     in   4            sets per job minus 1 (0 = one set)
//  ofifo_valid  in   1            ofifo holds a row
//  ofifo_out    in   COL*PSUM_BW  ofifo row, column 0 in LSBs
//  ofifo_rd     out  1            pop ofifo this cycle
//  pmem_rd      out  1            pmem read enable (sync read, data 1 cycle later)
//  pmem_wr      out  1            pmem write enable
//  pmem_add     out  ADDR_W       pmem address (shared read/write port)
//  pmem_din     out  COL*PSUM_BW  pmem write data
//  pmem_dout    in   COL*PSUM_BW  pmem read data
//  busy         out  1            job in progress
//  done         out  1            1-cycle pulse, job complete
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0; reset mid-job aborts, no partial done.
//  FSM: IDLE -start-> WR_DIRECT (set 0) -last row-> RMW_RD (set>=1) <-> RMW_WR -last row of
//       last set-> FINISH -> IDLE. If num_sets==0, WR_DIRECT last row -> FINISH.
//  WR_DIRECT: when ofifo_valid: ofifo_rd=1, pmem_wr=1, pmem_din=ofifo_out, pmem_add=row_cnt, same cycle.
//  RMW_RD: when ofifo_valid: ofifo_rd=1, pmem_rd=1, pmem_add=row_cnt; ofifo_out captured into hold reg.
//  RMW_WR (next cycle): pmem_wr=1, pmem_add=same row, pmem_din=hold+pmem_dout per column.
//  Throughput: 1 row/cycle in set 0; 1 row/2 cycles in RMW sets; ofifo_rd never asserted in RMW_WR.
//  No read/write collision: read and write of the same row are serialized by RMW_RD/RMW_WR.
//  row_cnt increments per committed row, wraps to 0 at num_rows-1 and set_cnt increments.
//  Stall: no ofifo_valid -> no pmem access, state/counters hold.
//  FINISH: done=1 for exactly one cycle, busy drops the same cycle; busy=1 from cycle after start.
//  start while busy ignored; ofifo rows arriving in IDLE are not popped.
//  Arithmetic: per-column signed PSUM_BW add, no width growth.
// CONFIGURATION
//  PSUM_ACCUM_SAT_EN defined: per-column sum saturates to +2**(PSUM_BW-1)-1 / -2**(PSUM_BW-1).
//  Not defined: two's-complement wrap-around (low PSUM_BW bits of the sum).
// STRUCTURE
//  psum_pkg: state encoding (IDLE, WR_DIRECT, RMW_RD, RMW_WR, FINISH), default COL/PSUM_BW/ADDR_W.
//  Sub-module psum_col_adder: one column add (+ saturation under macro), generated COL times.
// TESTING
//  start, num_rows=4, num_sets=0, rows r0..r3 back-to-back -> pmem[0..3]=r0..r3, 4 cycles, done once.
//  num_rows=2, num_sets=2, all columns 5 each set -> pmem[0..1] every column=15, done after last write.
//  PSUM_BW=16, set0=32767, set1=1 -> wrap build: -32768; PSUM_ACCUM_SAT_EN: 32767; -32768+(-1) -> 32767 / -32768.
//  ofifo_valid gaps of 3 cycles mid-set -> no pmem_rd/pmem_wr in gaps, final pmem contents unchanged.
//  reset asserted during RMW_WR of set 1 -> outputs 0 immediately, no done; new start runs cleanly.
//  start pulsed while busy -> ignored, job length/results unchanged; num_rows=0 -> behaves as 1.

Source files
------------

// File: rtl/psum_pkg.sv
// Shared definitions for the psum accumulation writer: FSM state encoding and default geometry.
package psum_pkg;

    localparam int DEF_COL     = 8;
    localparam int DEF_PSUM_BW = 16;
    localparam int DEF_ADDR_W  = 4;

    localparam int ROW_CNT_W = 5;
    localparam int SET_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR_DIRECT,
        RMW_RD,
        RMW_WR,
        FINISH
    } state_t;

endpackage

// File: rtl/psum_col_adder.sv
// One column of the psum accumulator: signed add with no width growth.
// Build option PSUM_ACCUM_SAT_EN: saturate to the signed range instead of wrapping.
module psum_col_adder
    import psum_pkg::*;
#(
    parameter int PSUM_BW = DEF_PSUM_BW
) (
    input  logic signed [PSUM_BW-1:0] a,
    input  logic signed [PSUM_BW-1:0] b,
    output logic signed [PSUM_BW-1:0] sum
);

`ifdef PSUM_ACCUM_SAT_EN
    localparam logic signed [PSUM_BW-1:0] SAT_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic signed [PSUM_BW-1:0] SAT_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    logic signed [PSUM_BW:0] wide;

    assign wide = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};

    // Top two bits disagree only when the true sum left the PSUM_BW range.
    always_comb begin
        sum = wide[PSUM_BW-1:0];
        if (wide[PSUM_BW] != wide[PSUM_BW-1]) begin
            sum = wide[PSUM_BW] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum = a + b;
`endif

endmodule

// File: rtl/psum_accum_writer.sv
// Drains ofifo rows into pmem: set 0 writes directly, later sets read-modify-write (pmem += row).
// Build option PSUM_ACCUM_SAT_EN selects saturating column adds (default: wrap-around).
module psum_accum_writer
    import psum_pkg::*;
#(
    parameter int COL     = DEF_COL,
    parameter int PSUM_BW = DEF_PSUM_BW,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4:0]              num_rows,
    input  logic [3:0]              num_sets,
    input  logic                    ofifo_valid,
    input  logic [COL*PSUM_BW-1:0]  ofifo_out,
    output logic                    ofifo_rd,
    output logic                    pmem_rd,
    output logic                    pmem_wr,
    output logic [ADDR_W-1:0]       pmem_add,
    output logic [COL*PSUM_BW-1:0]  pmem_din,
    input  logic [COL*PSUM_BW-1:0]  pmem_dout,
    output logic                    busy,
    output logic                    done
);

    localparam int ROW_W = COL * PSUM_BW;

    state_t                 state;
    state_t                 next_state;
    logic [ROW_CNT_W-1:0]   row_cnt;
    logic [ROW_CNT_W-1:0]   last_row;
    logic [SET_CNT_W-1:0]   set_cnt;
    logic [SET_CNT_W-1:0]   last_set;
    logic [ROW_W-1:0]       hold;
    logic [ROW_W-1:0]       sum_row;
    logic                   row_commit;
    logic                   last_row_hit;
    logic                   last_set_hit;

    assign row_commit   = ((state == WR_DIRECT) && ofifo_valid) || (state == RMW_WR);
    assign last_row_hit = (row_cnt == last_row);
    assign last_set_hit = (set_cnt == last_set);

    // Job geometry is stored as last indices so num_rows==0 naturally collapses to one row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            row_cnt  <= '0;
            set_cnt  <= '0;
            last_row <= '0;
            last_set <= '0;
            hold     <= '0;
        end else begin
            state <= next_state;
            if ((state == IDLE) && start) begin
                last_row <= (num_rows == 5'd0) ? 5'd0 : (num_rows - 5'd1);
                last_set <= num_sets;
                row_cnt  <= '0;
                set_cnt  <= '0;
            end else if (row_commit) begin
                if (last_row_hit) begin
                    row_cnt <= '0;
                    set_cnt <= last_set_hit ? '0 : (set_cnt + 4'd1);
                end else begin
                    row_cnt <= row_cnt + 5'd1;
                end
            end
            if ((state == RMW_RD) && ofifo_valid) begin
                hold <= ofifo_out;
            end
        end
    end

    always_comb begin
        next_state = state;
        ofifo_rd   = 1'b0;
        pmem_rd    = 1'b0;
        pmem_wr    = 1'b0;
        pmem_add   = '0;
        pmem_din   = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = WR_DIRECT;
                end
            end
            WR_DIRECT: begin
                busy = 1'b1;
                if (ofifo_valid) begin
                    ofifo_rd = 1'b1;
                    pmem_wr  = 1'b1;
                    pmem_add = ADDR_W'(row_cnt);
                    pmem_din = ofifo_out;
                    if (last_row_hit) begin
                        next_state = last_set_hit ? FINISH : RMW_RD;
                    end
                end
            end
            RMW_RD: begin
                busy = 1'b1;
                if (ofifo_valid) begin
                    ofifo_rd   = 1'b1;
                    pmem_rd    = 1'b1;
                    pmem_add   = ADDR_W'(row_cnt);
                    next_state = RMW_WR;
                end
            end
            RMW_WR: begin
                busy     = 1'b1;
                pmem_wr  = 1'b1;
                pmem_add = ADDR_W'(row_cnt);
                pmem_din = sum_row;
                next_state = (last_row_hit && last_set_hit) ? FINISH : RMW_RD;
            end
            FINISH: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    for (genvar c = 0; c < COL; c++) begin : g_col
        psum_col_adder #(
            .PSUM_BW (PSUM_BW)
        ) u_col_adder (
            .a   (hold[c*PSUM_BW +: PSUM_BW]),
            .b   (pmem_dout[c*PSUM_BW +: PSUM_BW]),
            .sum (sum_row[c*PSUM_BW +: PSUM_BW])
        );
    end

endmodule
